rect_fill_writer: RTL and testbench

- Pixel-write engine that draws a solid rectangle, given as one command, into the frame buffer through one buffer_ram_dp write port (addr_in/data_in/regwrite).
- Sits directly upstream of the dual-port RAM, between the game FSM (command source) and the RAM.
- Converts tile coordinates into raster-order single-pixel writes, one per clock, with screen clipping.
- Memory layout is row-major: addr = x + y*SCREEN_X.

---
 rtl/rect_fill_writer.sv | 157 +++++++++++++++
 tb/tb_rect_fill_writer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rect_fill_writer.sv
// Rectangle fill engine: one clipped raster-order pixel write per clock; first write 2 cycles after accept, done 2+w*h after.
// No backpressure on the RAM side; cmd_ready is high only in IDLE, and commands offered while busy wait at the source.
module rect_fill_writer #(
    parameter int AW       = 15,
    parameter int DW       = 3,
    parameter int SCREEN_X = 176,
    parameter int SCREEN_Y = 120,
    parameter int XW       = 8,
    parameter int YW       = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [XW-1:0] cmd_x,
    input  logic [YW-1:0] cmd_y,
    input  logic [XW-1:0] cmd_w,
    input  logic [YW-1:0] cmd_h,
    input  logic [DW-1:0] cmd_color,
    output logic [AW-1:0] mem_px_addr,
    output logic [DW-1:0] mem_px_data,
    output logic          px_wr,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {S_IDLE, S_CLIP, S_DRAW, S_FIN} state_t;

    localparam logic [XW:0]   SX_W   = (XW+1)'(SCREEN_X);
    localparam logic [YW:0]   SY_W   = (YW+1)'(SCREEN_Y);
    localparam logic [AW-1:0] STRIDE = AW'(SCREEN_X);

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d, w_q, w_d, col_q, col_d;
    logic [YW-1:0] y_q, y_d, h_q, h_d, row_q, row_d;
    logic [DW-1:0] color_q, color_d, data_q, data_d;
    logic [AW-1:0] row_base_q, row_base_d, addr_q, addr_d;
    logic          wr_q, wr_d, busy_q, busy_d, done_q, done_d;

    logic [XW:0]   x_room;
    logic [YW:0]   y_room;
    logic          empty;
    logic [XW-1:0] w_eff;
    logic [YW-1:0] h_eff;

    // Room left to the screen edge; only meaningful when the origin is on screen.
    assign x_room = SX_W - {1'b0, x_q};
    assign y_room = SY_W - {1'b0, y_q};
    assign empty  = ({1'b0, x_q} >= SX_W) || ({1'b0, y_q} >= SY_W) ||
                    (w_q == '0) || (h_q == '0);
    assign w_eff  = ({1'b0, w_q} < x_room) ? w_q : x_room[XW-1:0];
    assign h_eff  = ({1'b0, h_q} < y_room) ? h_q : y_room[YW-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            col_q      <= '0;
            row_q      <= '0;
            color_q    <= '0;
            data_q     <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            w_q        <= w_d;
            h_q        <= h_d;
            col_q      <= col_d;
            row_q      <= row_d;
            color_q    <= color_d;
            data_q     <= data_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        w_d        = w_q;
        h_d        = h_q;
        col_d      = col_q;
        row_d      = row_q;
        color_d    = color_q;
        data_d     = data_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        wr_d       = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    x_d     = cmd_x;
                    y_d     = cmd_y;
                    w_d     = cmd_w;
                    h_d     = cmd_h;
                    color_d = cmd_color;
                    busy_d  = 1'b1;
                    state_d = S_CLIP;
                end
            end
            S_CLIP: begin
                if (empty) begin
                    state_d = S_FIN;
                end else begin
                    // w/h are overwritten with their clipped extents for the draw loop.
                    w_d        = w_eff;
                    h_d        = h_eff;
                    row_base_d = AW'(y_q) * STRIDE;
                    col_d      = '0;
                    row_d      = '0;
                    state_d    = S_DRAW;
                end
            end
            S_DRAW: begin
                wr_d   = 1'b1;
                addr_d = row_base_q + AW'(x_q) + AW'(col_q);
                data_d = color_q;
                if (col_q == w_q - 1'b1) begin
                    col_d      = '0;
                    row_d      = row_q + 1'b1;
                    row_base_d = row_base_q + STRIDE;
                    if (row_q == h_q - 1'b1) state_d = S_FIN;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign mem_px_addr = addr_q;
    assign mem_px_data = data_q;
    assign px_wr       = wr_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_rect_fill_writer.sv
// Directed bench for rect_fill_writer: hand-computed addresses, write cycles and done timing.
module tb_rect_fill_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_x, cmd_w;
    logic [6:0]  cmd_y, cmd_h;
    logic [2:0]  cmd_color;
    logic [14:0] mem_px_addr;
    logic [2:0]  mem_px_data;
    logic        px_wr, busy, done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wa[$];
    int wd[$];
    int wc[$];
    int done_cnt = 0;
    int done_cyc = -1;
    int busy_cnt = 0;
    int over = 0;

    rect_fill_writer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_color(cmd_color), .mem_px_addr(mem_px_addr), .mem_px_data(mem_px_data),
        .px_wr(px_wr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (px_wr) begin
            wa.push_back(int'(mem_px_addr));
            wd.push_back(int'(mem_px_data));
            wc.push_back(cyc);
            if (mem_px_addr > 15'd21119) over++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_cnt++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        wa.delete(); wd.delete(); wc.delete();
        done_cnt = 0; done_cyc = -1; busy_cnt = 0;
    endtask

    task automatic tick();
        @(negedge clk); #1;
    endtask

    // Offers a command and returns the edge number at which it was accepted.
    task automatic issue(input int x, input int y, input int w, input int h, input int c,
                         input bit hold, output int acc);
        cmd_x = 8'(x); cmd_y = 7'(y); cmd_w = 8'(w); cmd_h = 7'(h); cmd_color = 3'(c);
        cmd_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 300; i++) begin
            if (cmd_ready) begin
                acc = cyc + 1;
                break;
            end
            tick();
        end
        chk("accept_seen", int'(acc >= 0), 1);
        tick();
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 400) begin
            tick();
            n++;
        end
        chk("done_seen", int'(done_cnt >= target), 1);
        tick();
    endtask

    task automatic check_writes(input string tag, input int ea[$], input int ed, input int first);
        chk({tag, "_nwr"}, wa.size(), ea.size());
        for (int i = 0; i < ea.size(); i++) begin
            if (i < wa.size()) begin
                chk($sformatf("%s_addr%0d", tag, i), wa[i], ea[i]);
                chk($sformatf("%s_data%0d", tag, i), wd[i], ed);
                chk($sformatf("%s_cyc%0d", tag, i), wc[i], first + i);
            end
        end
    endtask

    initial begin
        int acc, acc2;
        rst = 1'b0; cmd_valid = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
        repeat (3) tick();
        chk("rst_px_wr", int'(px_wr), 0);
        chk("rst_addr", int'(mem_px_addr), 0);
        chk("rst_data", int'(mem_px_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        rst = 1'b1;
        repeat (2) tick();

        clr();
        issue(0, 0, 1, 1, 3'b100, 1'b0, acc);
        wait_done(1);
        check_writes("single", '{0}, 4, acc + 2);
        chk("single_done_cyc", done_cyc, acc + 3);
        chk("single_busy_len", busy_cnt, 3);

        clr();
        issue(10, 5, 3, 2, 3'b010, 1'b0, acc);
        wait_done(1);
        check_writes("rect3x2", '{890, 891, 892, 1066, 1067, 1068}, 2, acc + 2);
        chk("rect3x2_done_cyc", done_cyc, acc + 8);

        clr();
        issue(174, 119, 5, 3, 3'b111, 1'b0, acc);
        wait_done(1);
        check_writes("clip", '{21118, 21119}, 7, acc + 2);
        chk("clip_done_cyc", done_cyc, acc + 4);

        clr();
        issue(175, 119, 255, 127, 3'b001, 1'b0, acc);
        wait_done(1);
        check_writes("maxwh", '{21119}, 1, acc + 2);

        clr();
        issue(5, 5, 0, 3, 3'b011, 1'b0, acc);
        wait_done(1);
        chk("w0_nwr", wa.size(), 0);
        chk("w0_done_cyc", done_cyc, acc + 2);
        chk("w0_ready", int'(cmd_ready), 1);

        clr();
        issue(176, 0, 4, 4, 3'b011, 1'b0, acc);
        wait_done(1);
        chk("x176_nwr", wa.size(), 0);
        chk("x176_done_cyc", done_cyc, acc + 2);
        chk("x176_ready", int'(cmd_ready), 1);

        clr();
        issue(0, 0, 2, 1, 3'b001, 1'b1, acc);
        issue(3, 2, 1, 1, 3'b111, 1'b0, acc2);
        wait_done(2);
        chk("b2b_accept2", acc2, acc + 5);
        chk("b2b_nwr", wa.size(), 3);
        if (wa.size() == 3) begin
            chk("b2b_a0", wa[0], 0);
            chk("b2b_a1", wa[1], 1);
            chk("b2b_a2", wa[2], 355);
            chk("b2b_d2", wd[2], 7);
            chk("b2b_c1", wc[1], acc + 3);
            chk("b2b_c2", wc[2], acc2 + 2);
        end

        clr();
        issue(0, 0, 10, 10, 3'b101, 1'b0, acc);
        for (int i = 0; i < 200 && wa.size() < 15; i++) tick();
        chk("rstmid_nwr", wa.size(), 15);
        if (wa.size() >= 15) chk("rstmid_a14", wa[14], 180);
        rst = 1'b0;
        #1;
        chk("rstmid_px_wr", int'(px_wr), 0);
        chk("rstmid_busy", int'(busy), 0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("rstmid_no_done", done_cnt, 0);
        chk("rstmid_ready", int'(cmd_ready), 1);
        chk("rstmid_nwr_after", wa.size(), 15);

        clr();
        issue(1, 1, 2, 2, 3'b110, 1'b0, acc);
        wait_done(1);
        check_writes("post_rst", '{177, 178, 353, 354}, 6, acc + 2);
        chk("post_rst_done_cyc", done_cyc, acc + 6);

        chk("no_overflow", over, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
